// File: rtl/audio_shifter.sv
// audio_shifter: serial output stage for the audio path.
// Takes one WIDTH-bit word per load handshake and shifts it MSB-first to the
// DAC over an SPI mode-0 link (sclk idles low, data changes on the falling
// edge, the DAC samples on the rising edge). cs_n frames each word and is held
// high for CS_GAP cycles between frames.
module audio_shifter #(
    parameter int WIDTH  = 76,  // bits per frame (>= 2)
    parameter int DIV    = 4,   // clk cycles per sclk half-period (>= 1)
    parameter int CS_GAP = 2    // clk cycles cs_n stays high after a frame (>= 1)
) (
    input  logic             clk,
    input  logic             rst,    // asynchronous, active-low
    input  logic             en,     // clock enable: low freezes everything
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             done,
    output logic             sclk,
    output logic             mosi,
    output logic             cs_n
);

    // Counter widths; a divide or gap of one still needs a one-bit counter.
    localparam int HC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BC_W = $clog2(WIDTH);
    localparam int GC_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    localparam logic [HC_W-1:0] HC_LAST = HC_W'(DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(CS_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e            state_q,  state_d;
    logic [WIDTH-1:0]  shreg_q,  shreg_d;   // remaining bits, next bit at MSB
    logic [HC_W-1:0]   hcnt_q,   hcnt_d;    // cycles spent in current sclk phase
    logic [BC_W-1:0]   bcnt_q,   bcnt_d;    // index of the bit on the wire
    logic [GC_W-1:0]   gcnt_q,   gcnt_d;    // cycles spent in the gap
    logic              sclk_q,   sclk_d;    // also marks low/high phase of a bit
    logic              mosi_q,   mosi_d;
    logic              cs_n_q,   cs_n_d;
    logic              done_q,   done_d;

    // Handshake is combinational so the controller sees it in the same cycle.
    assign ready = (state_q == S_IDLE) && en && rst;

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;
    assign done = done_q;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        shreg_d = shreg_q;
        hcnt_d  = hcnt_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        done_d  = 1'b0;     // done is a single-cycle pulse

        case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (load) begin
                    // Frame starts: first bit goes on the wire with cs_n low
                    // so it is stable for the whole first low phase.
                    state_d = S_SHIFT;
                    shreg_d = data;
                    hcnt_d  = '0;
                    bcnt_d  = '0;
                    cs_n_d  = 1'b0;
                    mosi_d  = data[WIDTH-1];
                end
            end

            S_SHIFT: begin
                if (hcnt_q == HC_LAST) begin
                    hcnt_d = '0;
                    if (!sclk_q) begin
                        // End of low phase: DAC samples on this rise.
                        sclk_d = 1'b1;
                    end else if (bcnt_q == BC_LAST) begin
                        // End of the last high phase: release the frame.
                        state_d = S_GAP;
                        gcnt_d  = '0;
                        sclk_d  = 1'b0;
                        mosi_d  = 1'b0;
                        cs_n_d  = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        // End of a high phase: sclk falls and the next bit
                        // appears on the same edge.
                        shreg_d = shreg_q << 1;
                        bcnt_d  = bcnt_q + 1'b1;
                        sclk_d  = 1'b0;
                        mosi_d  = shreg_q[WIDTH-2];
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end

            S_GAP: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (gcnt_q == GC_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    // State and registered outputs; en low freezes the whole block in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the shift register is only WIDTH flops, so it is reset along with the counters.
            state_q <= S_IDLE;
            shreg_q <= '0;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else if (en) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            shreg_q <= shreg_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_audio_shifter.sv
// Directed testbench for audio_shifter: table-driven frames at default
// parameters plus hand-written back-to-back, mid-frame reset and DIV=1 cases.
// Cycle numbering: the load is accepted on the edge closing cycle 0; outputs
// are sampled on the falling edge of each following cycle c = 1, 2, ...
module tb_audio_shifter;

    localparam int W = 76;
    localparam int CS_GAP = 2;

    localparam logic [W-1:0] D_A5 = 76'h9000_00000_00000_A5_000;
    localparam logic [W-1:0] D_5A = 76'h6000_00000_00000_5A_000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b1;
    logic load = 1'b0;
    logic load1 = 1'b0;
    logic [W-1:0] data = '0;
    logic [W-1:0] data1 = '0;

    logic ready, done, sclk, mosi, cs_n;
    logic ready1, done1, sclk1, mosi1, cs_n1;

    int total = 0;
    int bad = 0;

    audio_shifter #(.WIDTH(W), .DIV(4), .CS_GAP(CS_GAP)) u_dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
        .ready(ready), .done(done), .sclk(sclk), .mosi(mosi), .cs_n(cs_n)
    );

    audio_shifter #(.WIDTH(W), .DIV(1), .CS_GAP(CS_GAP)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load1), .data(data1),
        .ready(ready1), .done(done1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        int ign_at;      // cycle to pulse a stray load with all-ones data (0 = none)
        int stall_at;    // cycle at which en drops for 10 cycles (0 = none)
        int exp_rises;
        int exp_cs_low;
        int exp_done;
        int exp_ready;
    } vec_t;

    vec_t vecs[5];

    // Drive one frame from the default-parameter DUT and check it end to end.
    task automatic run_frame(input vec_t v, input int idx);
        logic [W-1:0] word = '0;
        int rises = 0, cs_low = 0, done_cyc = 0, done_cnt = 0, ready_cyc = 0;
        int stall_left = 0, sclk_idle = 0;
        logic prev_sclk = 1'b0;
        logic [4:0] snap = '0;
        string tag = $sformatf("v%0d", idx);
        @(negedge clk);
        check({tag, "_ready_before"}, W'(ready), W'(1'b1));
        data = v.data;
        load = 1'b1;
        for (int c = 1; c <= 3000 && ready_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) load = 1'b0;
            if (stall_left > 0) begin
                check({tag, "_stall_hold"}, W'({ready, done, sclk, mosi, cs_n}), W'(snap));
                stall_left--;
                if (stall_left == 0) en = 1'b1;
            end
            if (sclk && !prev_sclk) begin
                rises++;
                word = {word[W-2:0], mosi};
            end
            if (sclk && cs_n) sclk_idle++;
            prev_sclk = sclk;
            if (!cs_n) cs_low++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (done_cyc != 0 && ready) ready_cyc = c;
            if (v.ign_at != 0 && c == v.ign_at) begin
                load = 1'b1;
                data = '1;
            end else if (v.ign_at != 0 && c == v.ign_at + 1) begin
                load = 1'b0;
            end
            if (v.stall_at != 0 && c == v.stall_at) begin
                snap = {ready, done, sclk, mosi, cs_n};
                en = 1'b0;
                stall_left = 10;
            end
        end
        en = 1'b1;
        load = 1'b0;
        check({tag, "_word"}, word, v.data);
        check({tag, "_rises"}, W'(rises), W'(v.exp_rises));
        check({tag, "_cs_low"}, W'(cs_low), W'(v.exp_cs_low));
        check({tag, "_done_cycle"}, W'(done_cyc), W'(v.exp_done));
        check({tag, "_done_count"}, W'(done_cnt), W'(1));
        check({tag, "_ready_cycle"}, W'(ready_cyc), W'(v.exp_ready));
        check({tag, "_sclk_while_idle"}, W'(sclk_idle), W'(0));
    endtask

    initial begin
        // Hand-computed at DIV=4, WIDTH=76: shift 2*4*76=608 cycles, done at
        // 609, ready at 609+CS_GAP=611. A 10-cycle stall pushes all by 10.
        vecs[0] = '{D_A5, 0, 0, 76, 608, 609, 611};
        vecs[1] = '{76'hFEDC_BA987_65432_10_F0F, 0, 0, 76, 608, 609, 611};
        vecs[2] = '{D_A5, 200, 0, 76, 608, 609, 611};
        vecs[3] = '{D_5A, 0, 323, 76, 618, 619, 621};
        vecs[4] = '{76'h8000_00000_00000_00_001, 0, 0, 76, 608, 609, 611};

        // Reset values while rst is held low with en high.
        repeat (3) @(negedge clk);
        check("rst_outputs", W'({ready, done, sclk, mosi, cs_n}), W'(5'b00001));
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_ready", W'(ready), W'(1'b1));

        // First vector's leading bits must be 1,0,0,1.
        check("first_nibble", W'(D_A5[W-1 -: 4]), W'(4'b1001));

        for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

        // Back-to-back: load held high; accepts at cycles 0 and 611. Between
        // frames cs_n is high for the CS_GAP gap cycles plus the IDLE cycle in
        // which the next load is accepted.
        begin
            logic [W-1:0] w0 = '0, w1 = '0;
            int start0 = -1, start1 = -1, frame = -1, hi_between = 0;
            logic prev_cs = 1'b1, prev_sclk = 1'b0;
            @(negedge clk);
            data = D_A5;
            load = 1'b1;
            for (int c = 1; c <= 1400; c++) begin
                @(negedge clk);
                if (!cs_n && prev_cs) begin
                    frame++;
                    if (frame == 0) start0 = c - 1;
                    if (frame == 1) start1 = c - 1;
                end
                if (sclk && !prev_sclk) begin
                    if (frame == 0) w0 = {w0[W-2:0], mosi};
                    if (frame == 1) w1 = {w1[W-2:0], mosi};
                end
                if (cs_n && frame == 0) hi_between++;
                prev_cs = cs_n;
                prev_sclk = sclk;
                if (done && frame == 0) data = D_5A;
                if (done && frame == 1) begin
                    load = 1'b0;
                    break;
                end
            end
            load = 1'b0;
            check("b2b_start0", W'(start0), W'(0));
            check("b2b_start1", W'(start1), W'(611));
            check("b2b_cs_high", W'(hi_between), W'(1 + CS_GAP));
            check("b2b_word0", w0, D_A5);
            check("b2b_word1", w1, D_5A);
            repeat (4) @(negedge clk);
        end

        // Mid-frame reset during the high phase of bit 20 (cycles 165..168).
        @(negedge clk);
        data = D_A5;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (165) @(negedge clk);
        check("pre_reset_sclk", W'({sclk, cs_n}), W'(2'b10));
        rst = 1'b0;
        #1;
        check("mid_reset_outputs", W'({ready, done, sclk, mosi, cs_n}), W'(5'b00001));
        @(negedge clk);
        check("mid_reset_hold", W'({ready, done, sclk, mosi, cs_n}), W'(5'b00001));
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_ready", W'(ready), W'(1'b1));
        run_frame(vecs[0], 5);

        // DIV=1 instance: shift 2*1*76=152 cycles, done at 153, ready at 155.
        begin
            logic [W-1:0] word = '0;
            int rises = 0, cs_low = 0, done_cyc = 0, ready_cyc = 0;
            logic prev_sclk = 1'b0;
            @(negedge clk);
            data1 = D_A5;
            load1 = 1'b1;
            for (int c = 1; c <= 400 && ready_cyc == 0; c++) begin
                @(negedge clk);
                if (c == 1) load1 = 1'b0;
                if (sclk1 && !prev_sclk) begin
                    rises++;
                    word = {word[W-2:0], mosi1};
                end
                prev_sclk = sclk1;
                if (!cs_n1) cs_low++;
                if (done1 && done_cyc == 0) done_cyc = c;
                if (done_cyc != 0 && ready1) ready_cyc = c;
            end
            load1 = 1'b0;
            check("div1_word", word, D_A5);
            check("div1_rises", W'(rises), W'(76));
            check("div1_cs_low", W'(cs_low), W'(152));
            check("div1_done_cycle", W'(done_cyc), W'(153));
            check("div1_ready_cycle", W'(ready_cyc), W'(155));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
